// File: rtl/trace_readout.sv
// trace_readout: locks the sample RAMs for one frame and turns
// sample pairs into vertical trace spans in step with the raster.
module trace_readout #(
  parameter int REG_SIZE = 600,
  parameter int H_ORG    = 20,
  parameter int V_ORG    = 40,
  parameter int V_SPAN   = 440
) (
  input  logic       CLK100MHz,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       frame_start,
  input  logic       capture_done,
  input  logic       ch1_en,
  input  logic       ch2_en,
  output logic [9:0] rd_addr,
  input  logic [9:0] rd_data_1,
  input  logic [9:0] rd_data_2,
  output logic       buf_lock,
  output logic       frame_valid,
  output logic       pixel_ch1,
  output logic       pixel_ch2
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DRAW = 1'b1;

  localparam logic signed [10:0] HO = 11'(H_ORG);
  localparam logic signed [10:0] VO = 11'(V_ORG);
  localparam logic signed [10:0] XN = 11'(REG_SIZE);
  localparam logic signed [10:0] VS = 11'(V_SPAN);
  localparam logic [9:0] V_END = 10'(V_ORG + V_SPAN);
  localparam logic [9:0] CLIP  = 10'(V_SPAN - 1);

  function automatic logic [9:0] clip(input logic [9:0] d);
    return (d > CLIP) ? CLIP : d;
  endfunction

  logic [0:0] state_q, state_d;
  logic       pend_q, pend_d;
  logic       fv_q, fv_d;

  logic [9:0] rd_addr_q, rd_addr_d;
  logic       ok_a_q, ok_a_d;
  logic       first_a_q, first_a_d;
  logic signed [10:0] r_a_q, r_a_d;

  logic       ok_b_q;
  logic signed [10:0] r_b_q;
  logic [9:0] prv1_q, prv1_d, prv2_q, prv2_d;
  logic [9:0] lo1_q, lo1_d, hi1_q, hi1_d;
  logic [9:0] lo2_q, lo2_d, hi2_q, hi2_d;

  logic       pix1_q, pix1_d, pix2_q, pix2_d;

  logic signed [10:0] x_s;
  logic       x_in;
  logic [9:0] cur1, cur2, base1, base2;
  logic       r_ok;
  logic [9:0] r10;

  assign x_s  = $signed({1'b0, hcount}) - HO;
  assign x_in = (x_s >= 11'sd0) && (x_s < XN);

  // frame lock FSM; capture flags are caught on any clock
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q | capture_done;
    fv_d    = fv_q | capture_done;
    if (pix_en) begin
      unique case (state_q)
        IDLE: begin
          if (frame_start &&
              (pend_q || capture_done || fv_q)) begin
            state_d = DRAW;
            pend_d  = 1'b0;
          end
        end
        DRAW: begin
          if (vcount == V_END) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // stage A: column to RAM address
  always_comb begin
    rd_addr_d = rd_addr_q;
    ok_a_d    = x_in;
    first_a_d = x_in && (x_s == 11'sd0);
    r_a_d     = $signed({1'b0, vcount}) - VO;
    if (x_in) rd_addr_d = x_s[9:0];
  end

  // stage B: clamp samples and form the span to the previous column
  always_comb begin
    cur1   = clip(rd_data_1);
    cur2   = clip(rd_data_2);
    base1  = first_a_q ? cur1 : prv1_q;
    base2  = first_a_q ? cur2 : prv2_q;
    lo1_d  = (base1 < cur1) ? base1 : cur1;
    hi1_d  = (base1 < cur1) ? cur1 : base1;
    lo2_d  = (base2 < cur2) ? base2 : cur2;
    hi2_d  = (base2 < cur2) ? cur2 : base2;
    prv1_d = ok_a_q ? cur1 : prv1_q;
    prv2_d = ok_a_q ? cur2 : prv2_q;
  end

  // stage C: row hit test against the span
  always_comb begin
    r_ok   = (r_b_q >= 11'sd0) && (r_b_q < VS);
    r10    = r_b_q[9:0];
    pix1_d = (state_q == DRAW) && ch1_en && ok_b_q && r_ok &&
             (r10 >= lo1_q) && (r10 <= hi1_q);
    pix2_d = (state_q == DRAW) && ch2_en && ok_b_q && r_ok &&
             (r10 >= lo2_q) && (r10 <= hi2_q);
  end

  // control registers
  always_ff @(posedge CLK100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      fv_q    <= fv_d;
    end
  end

  // pixel pipeline registers, advanced on the pixel strobe
  always_ff @(posedge CLK100MHz or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
      ok_a_q    <= 1'b0;
      first_a_q <= 1'b0;
      r_a_q     <= '0;
      ok_b_q    <= 1'b0;
      r_b_q     <= '0;
      prv1_q    <= '0;
      prv2_q    <= '0;
      lo1_q     <= '0;
      hi1_q     <= '0;
      lo2_q     <= '0;
      hi2_q     <= '0;
      pix1_q    <= 1'b0;
      pix2_q    <= 1'b0;
    end else if (pix_en) begin
      rd_addr_q <= rd_addr_d;
      ok_a_q    <= ok_a_d;
      first_a_q <= first_a_d;
      r_a_q     <= r_a_d;
      ok_b_q    <= ok_a_q;
      r_b_q     <= r_a_q;
      prv1_q    <= prv1_d;
      prv2_q    <= prv2_d;
      lo1_q     <= lo1_d;
      hi1_q     <= hi1_d;
      lo2_q     <= lo2_d;
      hi2_q     <= hi2_d;
      pix1_q    <= pix1_d;
      pix2_q    <= pix2_d;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign buf_lock    = (state_q == DRAW);
  assign frame_valid = fv_q;
  assign pixel_ch1   = pix1_q;
  assign pixel_ch2   = pix2_q;

endmodule

// File: tb/tb_trace_readout.sv
// tb_trace_readout: raster-driven bench with a sample-level
// trace model, vector table and randomized frames.
module tb_trace_readout;

  logic       CLK100MHz = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_en = 1'b0;
  logic [9:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic       frame_start = 1'b0;
  logic       capture_done = 1'b0;
  logic       ch1_en = 1'b0;
  logic       ch2_en = 1'b0;
  logic [9:0] rd_addr;
  logic [9:0] rd_data_1 = '0;
  logic [9:0] rd_data_2 = '0;
  logic       buf_lock, frame_valid, pixel_ch1, pixel_ch2;

  trace_readout dut (
    .CLK100MHz(CLK100MHz), .rst_n(rst_n), .pix_en(pix_en),
    .hcount(hcount), .vcount(vcount),
    .frame_start(frame_start), .capture_done(capture_done),
    .ch1_en(ch1_en), .ch2_en(ch2_en), .rd_addr(rd_addr),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .buf_lock(buf_lock), .frame_valid(frame_valid),
    .pixel_ch1(pixel_ch1), .pixel_ch2(pixel_ch2)
  );

  always #5 CLK100MHz = ~CLK100MHz;

  logic [9:0] ram1 [0:1023];
  logic [9:0] ram2 [0:1023];

  always @(posedge CLK100MHz) begin
    rd_data_1 <= ram1[rd_addr];
    rd_data_2 <= ram2[rd_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit m_lock = 0, m_pend = 0, m_valid = 0;
  int hh1, hh2, vv1, vv2, nh = 0;
  bit hit1 [0:1023];
  bit hit2 [0:1023];

  typedef struct {
    bit en1;
    int v;
    int h;
    bit e1;
    bit e2;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int clampv(input int d);
    return (d > 439) ? 439 : d;
  endfunction

  // trace geometry straight from sample values
  function automatic bit model_hit(input int ch, input int h,
                                   input int v);
    int x, r, cur, prv, lo, hi;
    x = h - 20;
    r = v - 40;
    if (x < 0 || x >= 600 || r < 0 || r >= 440) return 0;
    cur = clampv(ch == 1 ? int'(ram1[x]) : int'(ram2[x]));
    if (x == 0) prv = cur;
    else prv = clampv(ch == 1 ? int'(ram1[x-1]) : int'(ram2[x-1]));
    lo = (prv < cur) ? prv : cur;
    hi = (prv < cur) ? cur : prv;
    return (r >= lo) && (r <= hi);
  endfunction

  task automatic tick(input int h, input int v, input bit fs,
                      input bit cd);
    bit lb, e1, e2;
    @(negedge CLK100MHz);
    pix_en = 1; hcount = 10'(h); vcount = 10'(v);
    frame_start = fs; capture_done = cd;
    lb = m_lock;
    if (cd) begin m_pend = 1; m_valid = 1; end
    if (!m_lock && fs && (m_pend || m_valid)) begin
      m_lock = 1; m_pend = 0;
    end else if (m_lock && v == 480) m_lock = 0;
    @(negedge CLK100MHz);
    pix_en = 0; frame_start = 0; capture_done = 0;
    chk("buf_lock", buf_lock, m_lock);
    chk("frame_valid", frame_valid, m_valid);
    if (nh >= 2) begin
      e1 = lb && ch1_en && model_hit(1, hh2, vv2);
      e2 = lb && ch2_en && model_hit(2, hh2, vv2);
      hit1[hh2] = pixel_ch1;
      hit2[hh2] = pixel_ch2;
    end else begin
      e1 = 0; e2 = 0;
    end
    chk("pixel_ch1", pixel_ch1, e1);
    chk("pixel_ch2", pixel_ch2, e2);
    hh2 = hh1; vv2 = vv1; hh1 = h; vv1 = v;
    nh++;
    @(negedge CLK100MHz);
    @(negedge CLK100MHz);
  endtask

  task automatic line(input int v, input int h0, input int h1);
    for (int h = 0; h < 1024; h++) begin
      hit1[h] = 0; hit2[h] = 0;
    end
    for (int h = h0; h <= h1; h++) tick(h, v, 0, 0);
    tick(700, v, 0, 0);
    tick(700, v, 0, 0);
  endtask

  task automatic flush();
    repeat (3) tick(700, 0, 0, 0);
  endtask

  task automatic cap();
    @(negedge CLK100MHz);
    capture_done = 1; m_pend = 1; m_valid = 1;
    @(negedge CLK100MHz);
    capture_done = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [12];
    int cnt, first, last;

    tbl[0]  = '{1, 89, 30, 0, 0};
    tbl[1]  = '{1, 90, 30, 1, 0};
    tbl[2]  = '{1, 240, 30, 1, 1};
    tbl[3]  = '{1, 340, 30, 1, 0};
    tbl[4]  = '{1, 341, 30, 0, 0};
    tbl[5]  = '{1, 90, 29, 1, 0};
    tbl[6]  = '{1, 139, 31, 0, 0};
    tbl[7]  = '{1, 478, 20, 0, 0};
    tbl[8]  = '{1, 479, 20, 1, 0};
    tbl[9]  = '{1, 479, 21, 1, 0};
    tbl[10] = '{1, 139, 21, 0, 0};
    tbl[11] = '{0, 479, 20, 0, 0};

    for (int i = 0; i < 1024; i++) begin
      ram1[i] = 10'd100; ram2[i] = 10'd200;
    end

    repeat (3) @(negedge CLK100MHz);
    chk("rst_buf_lock", buf_lock, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_pix1", pixel_ch1, 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    rst_n = 1;
    ch1_en = 1; ch2_en = 1;

    // no capture yet: frame_start must not lock
    tick(0, 0, 1, 0);
    chk("nocap_lock", buf_lock, 0);
    line(140, 0, 40);

    // flat ch1=100, ch2=200 over one frame
    cap();
    tick(0, 0, 1, 0);
    chk("lock_rise", buf_lock, 1);
    chk("fv_set", frame_valid, 1);
    line(139, 0, 625);
    cnt = 0;
    for (int h = 0; h < 1024; h++) cnt += int'(hit1[h]);
    chk("row139_cnt", cnt, 0);
    line(140, 0, 625);
    cnt = 0; first = -1; last = -1;
    for (int h = 0; h < 1024; h++)
      if (hit1[h]) begin
        cnt++;
        if (first < 0) first = h;
        last = h;
      end
    chk("row140_cnt", cnt, 600);
    chk("row140_first", first, 20);
    chk("row140_last", last, 619);
    cnt = 0;
    for (int h = 0; h < 1024; h++) cnt += int'(hit2[h]);
    chk("row140_ch2", cnt, 0);
    tick(0, 479, 0, 0);
    chk("lock_479", buf_lock, 1);
    tick(0, 480, 0, 0);
    chk("unlock_480", buf_lock, 0);

    // asynchronous reset in the middle of a drawn row
    tick(0, 0, 1, 0);
    for (int h = 0; h <= 30; h++) tick(h, 140, 0, 0);
    chk("pre_rst_pix", pixel_ch1, 1);
    @(negedge CLK100MHz);
    rst_n = 0;
    #1;
    chk("rst_drop_lock", buf_lock, 0);
    chk("rst_drop_pix", pixel_ch1, 0);
    chk("rst_drop_fv", frame_valid, 0);
    m_lock = 0; m_pend = 0; m_valid = 0; nh = 0;
    repeat (2) @(negedge CLK100MHz);
    rst_n = 1;
    tick(0, 0, 1, 0);
    chk("no_relock", buf_lock, 0);
    line(140, 0, 40);

    // steep edge and clamped sample, vector table
    flush();
    ram1[0] = 10'd1023; ram1[9] = 10'd50; ram1[10] = 10'd300;
    tick(0, 0, 1, 1);
    chk("cd_fs_lock", buf_lock, 1);
    foreach (tbl[i]) begin
      ch1_en = tbl[i].en1;
      line(tbl[i].v, 0, 40);
      chk($sformatf("tbl%0d_ch1", i), hit1[tbl[i].h], tbl[i].e1);
      chk($sformatf("tbl%0d_ch2", i), hit2[tbl[i].h], tbl[i].e2);
    end
    ch1_en = 1;
    tick(0, 480, 0, 0);
    chk("tbl_unlock", buf_lock, 0);

    // randomized frames against the model
    for (int it = 0; it < 6; it++) begin
      flush();
      for (int i = 0; i < 600; i++) begin
        ram1[i] = 10'($urandom_range(0, 1023));
        ram2[i] = 10'($urandom_range(0, 500));
      end
      ch1_en = 1'($urandom_range(0, 3) != 0);
      ch2_en = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) cap();
      tick(0, 0, 1, 1'($urandom_range(0, 3) == 0));
      for (int l = 0; l < 2; l++) begin
        line($urandom_range(30, 485), $urandom_range(0, 20),
             $urandom_range(20, 640));
        if ($urandom_range(0, 3) == 0) cap();
      end
      tick(0, 480, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
